intc_cpuif_mp: RTL and testbench
================================

Name: intc_cpuif_mp

Overview:
- Parametrised multi-CPU interrupt CPU interface for the interrupt controller (intc) core.
- Sits between the per-CPU interrupt selector (sl_*) and each CPU's interrupt request/acknowledge port.
- Runs an independent request/acknowledge state machine per CPU, with three features:
  - Higher-priority update of a pending request.
  - Source-withdrawal cancel.
  - Post-acknowledge hold-off.
- Decodes each accepted vector into per-source acknowledge pulses, OR-reduced across any number of CPUs.

Parameters:
- CPU_NUM, 2, number of CPU interfaces (1..16, no upper special-casing).
- REG_NUM, 1, normal interrupt sources = REG_NUM*32.
- VEC_BASE, 64, vector of normal source 0; source i uses vector VEC_BASE+i; VEC_BASE+REG_NUM*32 <= 256 is required.
- NMI_VEC, 11, vector identifying NMI.
- ERR_VEC, 9, vector identifying bus-error interrupt.
- HOLD_CYC, 2, hold-off cycles after an acknowledge (0..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- sync_cpu_int_i  in  1  sampling strobe; selector outputs are captured only when high.
- intr_req_o  out  CPU_NUM  interrupt request to each CPU.
- intr_level_o  out  CPU_NUM x 5  level of the pending request.
- intr_vec_o  out  CPU_NUM x 8  vector of the pending request.
- inta_ack_i  in  CPU_NUM  CPU acknowledge, one-cycle pulse.
- sl_req_i  in  CPU_NUM  selector request.
- sl_level_i  in  CPU_NUM x 5  selector level.
- sl_vec_i  in  CPU_NUM x 8  selector vector.
- cp_intack_nmi_o  out  CPU_NUM  NMI acknowledged pulse.
- cp_intack_err_o  out  CPU_NUM  error interrupt acknowledged pulse.
- cp_intack_o  out  REG_NUM*32  per-source acknowledge pulse, OR over all CPUs.
- cp_intack_all_o  out  CPU_NUM  any-acknowledge pulse.
- spur_ack_o  out  CPU_NUM  acknowledge received with no pending request.

Behaviour:
- Clock and reset:
  - rst_n is sampled on the clk rising edge only.
  - While low, every output is 0, every FSM is in IDLE, latched level/vector are 0 and hold counters are 0.
  - Reset mid-request drops intr_req_o on the next edge with no acknowledge pulses.
- All outputs are registered. Per-CPU FSM (index k):
  - IDLE:
    - If sync_cpu_int_i & sl_req_i[k]: latch sl_level_i/sl_vec_i, go REQ.
    - intr_req_o[k] = 1 from the next cycle, i.e. one-cycle latency.
  - REQ, priorities 1..3 evaluated in order:
    - (1) inta_ack_i[k]: go ACK with the currently latched vector.
    - (2) sync_cpu_int_i & !sl_req_i[k]: withdraw; intr_req_o[k] drops next cycle; go IDLE; no acknowledge pulses.
    - (3) sync_cpu_int_i & sl_req_i[k] & sl_level_i[k] > latched level (unsigned 5-bit compare): re-latch level and vector, stay REQ. Equal or lower level leaves the latch unchanged.
    - Ack in the same cycle as an update or withdraw: the ack wins and the old latched vector is acknowledged.
  - ACK (exactly one cycle):
    - intr_req_o[k] = 0.
    - Decoded pulses are high for this single cycle, i.e. one cycle after inta_ack_i.
    - Next state is HOLD if HOLD_CYC > 0, else IDLE.
  - HOLD:
    - Counter loads HOLD_CYC-1 on entry and decrements; go IDLE when it reaches 0.
    - Selector requests are ignored while in HOLD.
    - inta_ack_i in HOLD raises spur_ack_o.
- Vector decode, applied on ACK:
  - cp_intack_all_o[k] = 1 always.
  - Latched vec == NMI_VEC gives cp_intack_nmi_o[k].
  - Latched vec == ERR_VEC gives cp_intack_err_o[k].
  - VEC_BASE <= vec < VEC_BASE+REG_NUM*32 gives a one-hot on bit (vec-VEC_BASE) of that CPU's vector.
  - Any other vector gives only cp_intack_all_o.
  - cp_intack_o is the bitwise OR of all CPU one-hots. Two CPUs acknowledging the same source in the same cycle give a single high bit.
- Spurious acknowledge: inta_ack_i[k] in IDLE or HOLD gives spur_ack_o[k] = 1 for one cycle and no other effect.
- CPUs are fully independent; no cross-CPU arbitration.

Test Plan:
- Basic request/acknowledge:
  - Stimulus: reset, then CPU0 sl_req=1, level 5, vec 70, sync=1; ack 3 cycles later.
  - Required: intr_req_o[0]=1 one cycle after the sync cycle with level 5 / vec 70.
  - Required: one cycle after the ack, cp_intack_o[6], cp_intack_all_o[0] and intr_req_o[0]=0; idle for 2 cycles (HOLD), then a new request is accepted.
- Priority update:
  - Stimulus: pending level 3, vec 65; selector presents level 9, vec 80 with sync.
  - Required: intr_level_o=9, intr_vec_o=80 next cycle.
  - Stimulus: selector then presents level 9, vec 81.
  - Required: no change.
- Withdraw vs ack race:
  - Stimulus: sl_req drops with sync.
  - Required: request cleared, no acknowledge pulses.
  - Stimulus: repeat with inta_ack in the same cycle.
  - Required: cp_intack_o bit of the latched vector pulses.
- NMI/ERR/out-of-range:
  - Stimulus: acks of vec 11, 9 and 200.
  - Required: cp_intack_nmi_o only, cp_intack_err_o only, cp_intack_all_o only respectively.
- Multi-CPU OR and spurious (CPU_NUM=4):
  - Stimulus: CPU1 and CPU3 acknowledge vec 64 in the same cycle.
  - Required: cp_intack_o[0]=1 for one cycle.
  - Stimulus: ack to idle CPU2.
  - Required: spur_ack_o[2]=1 only.
- Reset mid-request:
  - Stimulus: rst_n low while in REQ.
  - Required: all outputs 0 next edge, no pulses.

Source files
------------

// File: rtl/intc_cpuif_mp.sv
// Multi-CPU interrupt CPU interface: one request/acknowledge engine per CPU,
// plus acknowledge vector decode OR-reduced over all CPUs.

module intc_cpuif_lane #(
  parameter int NSRC     = 32,
  parameter int VEC_BASE = 64,
  parameter int NMI_VEC  = 11,
  parameter int ERR_VEC  = 9,
  parameter int HOLD_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sync,
  input  logic            sl_req,
  input  logic [4:0]      sl_level,
  input  logic [7:0]      sl_vec,
  input  logic            ack,
  output logic            req,
  output logic [4:0]      level,
  output logic [7:0]      vec,
  output logic            ack_nmi,
  output logic            ack_err,
  output logic            ack_all,
  output logic            spur,
  output logic [NSRC-1:0] onehot_nxt
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [4:0]  lvl_nxt;
  logic [7:0]  vec_nxt;
  logic        ack_fire;
  logic        in_rng;
  logic [8:0]  vec9;
  logic [7:0]  idx;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lvl_nxt   = level;
    vec_nxt   = vec;
    case (state)
      IDLE: if (sync && sl_req) begin
        lvl_nxt   = sl_level;
        vec_nxt   = sl_vec;
        state_nxt = REQ;
      end
      REQ: begin
        // Ack outranks withdraw/update so the vector the CPU saw is the one acknowledged.
        if (ack)
          state_nxt = ACK;
        else if (sync && !sl_req)
          state_nxt = IDLE;
        else if (sync && (sl_level > level)) begin
          lvl_nxt = sl_level;
          vec_nxt = sl_vec;
        end
      end
      ACK: begin
        if (HOLD_CYC > 0) begin
          state_nxt = HOLD;
          cnt_nxt   = 4'(HOLD_CYC - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ack_fire = (state == REQ) && ack;
  assign vec9     = {1'b0, vec};
  assign in_rng   = (vec9 >= 9'(VEC_BASE)) && (vec9 < 9'(VEC_BASE + NSRC));
  assign idx      = vec - 8'(VEC_BASE);
  // Left unregistered here; the top registers the cross-CPU OR.
  assign onehot_nxt = (ack_fire && in_rng) ? ({{(NSRC-1){1'b0}}, 1'b1} << idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      level   <= '0;
      vec     <= '0;
      req     <= 1'b0;
      ack_nmi <= 1'b0;
      ack_err <= 1'b0;
      ack_all <= 1'b0;
      spur    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level   <= lvl_nxt;
      vec     <= vec_nxt;
      req     <= (state_nxt == REQ);
      ack_nmi <= ack_fire && (vec == 8'(NMI_VEC));
      ack_err <= ack_fire && (vec == 8'(ERR_VEC));
      ack_all <= ack_fire;
      spur    <= ack && ((state == IDLE) || (state == HOLD));
    end
  end

endmodule

module intc_cpuif_mp #(
  parameter int CPU_NUM  = 2,
  parameter int REG_NUM  = 1,
  parameter int VEC_BASE = 64,
  parameter int NMI_VEC  = 11,
  parameter int ERR_VEC  = 9,
  parameter int HOLD_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync_cpu_int_i,
  output logic [CPU_NUM-1:0]            intr_req_o,
  output logic [CPU_NUM-1:0][4:0]       intr_level_o,
  output logic [CPU_NUM-1:0][7:0]       intr_vec_o,
  input  logic [CPU_NUM-1:0]            inta_ack_i,
  input  logic [CPU_NUM-1:0]            sl_req_i,
  input  logic [CPU_NUM-1:0][4:0]       sl_level_i,
  input  logic [CPU_NUM-1:0][7:0]       sl_vec_i,
  output logic [CPU_NUM-1:0]            cp_intack_nmi_o,
  output logic [CPU_NUM-1:0]            cp_intack_err_o,
  output logic [REG_NUM*32-1:0]         cp_intack_o,
  output logic [CPU_NUM-1:0]            cp_intack_all_o,
  output logic [CPU_NUM-1:0]            spur_ack_o
);

  localparam int NSRC = REG_NUM * 32;

  logic [CPU_NUM-1:0][NSRC-1:0] onehot_nxt;
  logic [NSRC-1:0]              intack_nxt;

  for (genvar k = 0; k < CPU_NUM; k++) begin : g_lane
    intc_cpuif_lane #(
      .NSRC     (NSRC),
      .VEC_BASE (VEC_BASE),
      .NMI_VEC  (NMI_VEC),
      .ERR_VEC  (ERR_VEC),
      .HOLD_CYC (HOLD_CYC)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync       (sync_cpu_int_i),
      .sl_req     (sl_req_i[k]),
      .sl_level   (sl_level_i[k]),
      .sl_vec     (sl_vec_i[k]),
      .ack        (inta_ack_i[k]),
      .req        (intr_req_o[k]),
      .level      (intr_level_o[k]),
      .vec        (intr_vec_o[k]),
      .ack_nmi    (cp_intack_nmi_o[k]),
      .ack_err    (cp_intack_err_o[k]),
      .ack_all    (cp_intack_all_o[k]),
      .spur       (spur_ack_o[k]),
      .onehot_nxt (onehot_nxt[k])
    );
  end

  always_comb begin
    intack_nxt = '0;
    for (int k = 0; k < CPU_NUM; k++) intack_nxt = intack_nxt | onehot_nxt[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cp_intack_o <= '0;
    else        cp_intack_o <= intack_nxt;
  end

endmodule

// File: tb/tb_intc_cpuif_mp.sv
// Directed bench for intc_cpuif_mp (4 CPUs): per-cycle check against a
// pending/hold-off behavioural model plus hand-computed literal checks.

module tb_intc_cpuif_mp;

  localparam int CPU_NUM  = 4;
  localparam int HOLD_CYC = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    sync;
  logic [CPU_NUM-1:0]      intr_req, ack, sl_req, nmi, err, all, spur;
  logic [CPU_NUM-1:0][4:0] intr_level, sl_level;
  logic [CPU_NUM-1:0][7:0] intr_vec, sl_vec;
  logic [31:0]             cp;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  intc_cpuif_mp #(.CPU_NUM(CPU_NUM), .REG_NUM(1), .VEC_BASE(64), .NMI_VEC(11),
                  .ERR_VEC(9), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .sync_cpu_int_i(sync),
    .intr_req_o(intr_req), .intr_level_o(intr_level), .intr_vec_o(intr_vec),
    .inta_ack_i(ack), .sl_req_i(sl_req), .sl_level_i(sl_level), .sl_vec_i(sl_vec),
    .cp_intack_nmi_o(nmi), .cp_intack_err_o(err), .cp_intack_o(cp),
    .cp_intack_all_o(all), .spur_ack_o(spur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Model: a CPU is either pending (with a latched level/vector), in the
  // single acknowledge cycle, in hold-off, or free to accept.
  bit  m_pend [CPU_NUM];
  int  m_lvl  [CPU_NUM];
  int  m_vec  [CPU_NUM];
  bit  m_ackc [CPU_NUM];
  int  m_hold [CPU_NUM];
  logic [CPU_NUM-1:0]      e_req, e_nmi, e_err, e_all, e_spur;
  logic [CPU_NUM-1:0][4:0] e_lvl;
  logic [CPU_NUM-1:0][7:0] e_vec;
  logic [31:0]             e_cp;

  always @(posedge clk) begin
    e_nmi = '0; e_err = '0; e_all = '0; e_spur = '0; e_cp = '0;
    for (int k = 0; k < CPU_NUM; k++) begin
      if (!rst_n) begin
        m_pend[k] = 0; m_lvl[k] = 0; m_vec[k] = 0; m_ackc[k] = 0; m_hold[k] = 0;
      end else if (m_ackc[k]) begin
        m_ackc[k] = 0;
      end else if (m_hold[k] > 0) begin
        e_spur[k] = ack[k];
        m_hold[k]--;
      end else if (!m_pend[k]) begin
        e_spur[k] = ack[k];
        if (sync && sl_req[k]) begin
          m_pend[k] = 1; m_lvl[k] = sl_level[k]; m_vec[k] = sl_vec[k];
        end
      end else if (ack[k]) begin
        m_pend[k] = 0; m_ackc[k] = 1; m_hold[k] = HOLD_CYC;
        e_all[k] = 1'b1;
        e_nmi[k] = (m_vec[k] == 11);
        e_err[k] = (m_vec[k] == 9);
        if (m_vec[k] >= 64 && m_vec[k] < 96) e_cp[m_vec[k] - 64] = 1'b1;
      end else if (sync && !sl_req[k]) begin
        m_pend[k] = 0;
      end else if (sync && int'(sl_level[k]) > m_lvl[k]) begin
        m_lvl[k] = sl_level[k]; m_vec[k] = sl_vec[k];
      end
      e_req[k] = m_pend[k];
      e_lvl[k] = 5'(m_lvl[k]);
      e_vec[k] = 8'(m_vec[k]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_req",   64'(intr_req),   64'(e_req));
      chk("model_level", 64'(intr_level), 64'(e_lvl));
      chk("model_vec",   64'(intr_vec),   64'(e_vec));
      chk("model_nmi",   64'(nmi),        64'(e_nmi));
      chk("model_err",   64'(err),        64'(e_err));
      chk("model_all",   64'(all),        64'(e_all));
      chk("model_spur",  64'(spur),       64'(e_spur));
      chk("model_cp",    64'(cp),         64'(e_cp));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ack_vec0(input logic [7:0] v, input logic [3:0] en, input logic [3:0] ee,
                          input logic [31:0] ec, input string name);
    sl_req[0] = 1'b1; sl_level[0] = 5'd1; sl_vec[0] = v; sync = 1'b1;
    tick();
    sync = 1'b0; sl_req[0] = 1'b0; ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk({name, "_nmi"}, 64'(nmi), 64'(en));
    chk({name, "_err"}, 64'(err), 64'(ee));
    chk({name, "_all"}, 64'(all), 64'h1);
    chk({name, "_cp"},  64'(cp),  64'(ec));
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; ack = '0; sl_req = '0; sl_level = '0; sl_vec = '0;
    tick(); chk_en = 1'b1;
    tick();
    chk("rst_req", 64'(intr_req), 64'h0);
    chk("rst_vec", 64'(intr_vec), 64'h0);

    // basic request/ack with hold-off
    rst_n = 1'b1;
    sl_req[0] = 1'b1; sl_level[0] = 5'd5; sl_vec[0] = 8'd70; sync = 1'b1;
    tick();
    chk("basic_req", 64'(intr_req[0]), 64'h1);
    chk("basic_lvl", 64'(intr_level[0]), 64'd5);
    chk("basic_vec", 64'(intr_vec[0]), 64'd70);
    sync = 1'b0;
    repeat (2) tick();
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0; sync = 1'b1;
    chk("basic_cp",  64'(cp), 64'h40);
    chk("basic_all", 64'(all), 64'h1);
    chk("basic_req_drop", 64'(intr_req[0]), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_no_req", 64'(intr_req[0]), 64'h0);
    end
    tick();
    chk("hold_reaccept", 64'(intr_req[0]), 64'h1);
    sl_req[0] = 1'b0;
    tick();
    chk("withdraw_req", 64'(intr_req[0]), 64'h0);

    // priority update
    sl_req[0] = 1'b1; sl_level[0] = 5'd3; sl_vec[0] = 8'd65;
    tick();
    sl_level[0] = 5'd9; sl_vec[0] = 8'd80;
    tick();
    chk("upd_lvl", 64'(intr_level[0]), 64'd9);
    chk("upd_vec", 64'(intr_vec[0]), 64'd80);
    sl_vec[0] = 8'd81;
    tick();
    chk("eq_lvl_vec", 64'(intr_vec[0]), 64'd80);
    sl_level[0] = 5'd2; sl_vec[0] = 8'd90;
    tick();
    chk("low_lvl", 64'(intr_level[0]), 64'd9);
    sl_req[0] = 1'b0;
    tick();
    chk("wd_req", 64'(intr_req[0]), 64'h0);
    chk("wd_all", 64'(all), 64'h0);

    // withdraw racing an ack: ack wins, old vector acknowledged
    sl_req[0] = 1'b1; sl_level[0] = 5'd4; sl_vec[0] = 8'd66;
    tick();
    sl_req[0] = 1'b0; ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0; sync = 1'b0;
    chk("race_cp", 64'(cp), 64'h4);
    chk("race_req", 64'(intr_req[0]), 64'h0);
    repeat (3) tick();

    // NMI / ERR / out-of-range vectors
    ack_vec0(8'd11,  4'h1, 4'h0, 32'h0, "nmi");
    ack_vec0(8'd9,   4'h0, 4'h1, 32'h0, "err");
    ack_vec0(8'd200, 4'h0, 4'h0, 32'h0, "oor");

    // two CPUs acknowledging the same source, then a spurious ack
    sl_req = 4'b1010; sl_vec[1] = 8'd64; sl_vec[3] = 8'd64;
    sl_level[1] = 5'd1; sl_level[3] = 5'd1; sync = 1'b1;
    tick();
    sync = 1'b0; sl_req = '0; ack = 4'b1010;
    tick();
    chk("or_cp",  64'(cp), 64'h1);
    chk("or_all", 64'(all), 64'ha);
    ack = 4'b0100;
    tick();
    ack = '0;
    chk("or_cp_once", 64'(cp), 64'h0);
    chk("spur2", 64'(spur), 64'h4);
    repeat (3) tick();

    // reset while a request is pending
    sl_req[0] = 1'b1; sl_level[0] = 5'd5; sl_vec[0] = 8'd70; sync = 1'b1;
    tick();
    chk("pre_rst_req", 64'(intr_req[0]), 64'h1);
    rst_n = 1'b0; ack[0] = 1'b1; sync = 1'b0; sl_req = '0;
    tick();
    chk("rst_mid_req", 64'(intr_req), 64'h0);
    chk("rst_mid_all", 64'(all), 64'h0);
    chk("rst_mid_cp",  64'(cp), 64'h0);
    chk("rst_mid_lvl", 64'(intr_level), 64'h0);
    rst_n = 1'b1; ack = '0;
    tick();
    chk("post_rst_all", 64'(all), 64'h0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
